// File: rtl/weak_bus_pkg.sv
// Shared definitions for the weak bus: data width, wait-counter width, FSM encoding
// and the address legality helper used by the optional bounds check.
package weak_bus_pkg;

  localparam int unsigned BusWidth     = 32;
  localparam int unsigned WaitCntWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } state_t;

  // Misaligned, or beyond the last word of a 2**aw word array.
  function automatic logic addr_bad(input logic [BusWidth-1:0] addr, input int unsigned aw);
    logic [BusWidth-1:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/weak_ram_array.sv
// Single-port synchronous word storage: one write or one registered read per edge.
// Contents are deliberately not reset.
module weak_ram_array
  import weak_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [AW-1:0]       i_idx,
  input  logic [BusWidth-1:0] i_wdata,
  output logic [BusWidth-1:0] o_rdata
);

  logic [BusWidth-1:0] r_mem [DEPTH_WORDS];
  logic [BusWidth-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/weak_ram.sv
// Wait-stated word RAM behind a req/ack bus. Define WEAK_RAM_BOUNDS_CHECK_EN to reject
// misaligned or out-of-range accesses and raise a sticky bus_fault.
module weak_ram
  import weak_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_req,
  input  logic                bus_wr,
  input  logic [BusWidth-1:0] bus_addr,
  input  logic [BusWidth-1:0] bus_wdata,
  output logic [BusWidth-1:0] bus_rdata,
  output logic                bus_ack,
  output logic                bus_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t                  r_state;
  logic [WaitCntWidth-1:0] r_cnt;
  logic [BusWidth-1:0]     r_addr;
  logic [BusWidth-1:0]     r_wdata;
  logic                    r_wr;
  logic                    r_ack;

  logic                    w_accept;
  logic                    w_to_ack;
  logic [BusWidth-1:0]     w_src_addr;
  logic [BusWidth-1:0]     w_src_wdata;
  logic                    w_src_wr;
  logic                    w_src_bad;
  logic                    w_lat_bad;
  logic                    w_we;
  logic                    w_re;
  logic [BusWidth-1:0]     w_arr_rdata;

  assign w_accept = (r_state == StIdle) && bus_req;
  assign w_to_ack = (w_accept && (WAIT_CYCLES == 0)) ||
                    ((r_state == StWait) && (r_cnt == '0));

  // With zero wait states the array is accessed on the accepting edge itself, before the
  // latch registers hold the request, so the bus inputs feed the array directly.
  assign w_src_addr  = (r_state == StIdle) ? bus_addr  : r_addr;
  assign w_src_wdata = (r_state == StIdle) ? bus_wdata : r_wdata;
  assign w_src_wr    = (r_state == StIdle) ? bus_wr    : r_wr;

`ifdef WEAK_RAM_BOUNDS_CHECK_EN
  logic r_fault;

  assign w_src_bad = addr_bad(w_src_addr, AW);
  assign w_lat_bad = addr_bad(r_addr, AW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else if (w_accept && w_src_bad) begin
      r_fault <= 1'b1;
    end
  end

  assign bus_fault = r_fault;
`else
  logic w_unused_addr;

  assign w_src_bad     = 1'b0;
  assign w_lat_bad     = 1'b0;
  assign w_unused_addr = ^{w_src_addr[BusWidth-1:AW+2], w_src_addr[1:0]};
  assign bus_fault     = 1'b0;
`endif

  assign w_we = w_to_ack && w_src_wr && !w_src_bad;
  assign w_re = w_to_ack && !w_src_wr && !w_src_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ack <= 1'b0;
          if (bus_req) begin
            r_addr  <= bus_addr;
            r_wdata <= bus_wdata;
            r_wr    <= bus_wr;
            if (WAIT_CYCLES == 0) begin
              r_state <= StAck;
              r_ack   <= 1'b1;
            end else begin
              r_state <= StWait;
              r_cnt   <= WaitCntWidth'(WAIT_CYCLES - 1);
            end
          end
        end
        StWait: begin
          if (r_cnt == '0) begin
            r_state <= StAck;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StAck: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  weak_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (w_src_addr[AW+1:2]),
    .i_wdata(w_src_wdata),
    .o_rdata(w_arr_rdata)
  );

  assign bus_ack   = r_ack;
  assign bus_rdata = (r_ack && !r_wr && !w_lat_bad) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_weak_ram.sv
// Directed bench for weak_ram with WAIT_CYCLES 0, 1 and 3 instances on shared bus inputs.
// Expectations follow WEAK_RAM_BOUNDS_CHECK_EN when it is defined.
module tb_weak_ram;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ack0, ack1, ack3;
  logic        fault0, fault1, fault3;

  int tests_run = 0;
  int tests_failed = 0;

  weak_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus_req(req), .bus_wr(wr), .bus_addr(addr), .bus_wdata(wdata),
    .bus_rdata(rdata0), .bus_ack(ack0), .bus_fault(fault0)
  );
  weak_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus_req(req), .bus_wr(wr), .bus_addr(addr), .bus_wdata(wdata),
    .bus_rdata(rdata1), .bus_ack(ack1), .bus_fault(fault1)
  );
  weak_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus_req(req), .bus_wr(wr), .bus_addr(addr), .bus_wdata(wdata),
    .bus_rdata(rdata3), .bus_ack(ack3), .bus_fault(fault3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack0 : (sel == 1) ? ack1 : ack3;
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata3;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one transfer and returns its latency in edges (accepting edge included), -1 on timeout.
  task automatic xfer(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    logic seen;
    seen = 1'b0;
    rd   = '0;
    lat  = 0;
    req  = 1'b1;
    wr   = w;
    addr = a;
    wdata = d;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack_of(sel)) begin
        seen = 1'b1;
        rd   = rdata_of(sel);
      end
    end
    req = 1'b0;
    if (!seen) lat = -1;
    idle(7);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    tests_run++;
    if ({ack0, rdata0, fault0} !== 34'h0) begin
      $display("FAIL reset_dut0 got ack=%b rdata=%h fault=%b want 0 0 0", ack0, rdata0, fault0);
      tests_failed++;
    end
    tests_run++;
    if ({ack1, rdata1, fault1} !== 34'h0) begin
      $display("FAIL reset_dut1 got ack=%b rdata=%h fault=%b want 0 0 0", ack1, rdata1, fault1);
      tests_failed++;
    end
    tests_run++;
    if ({ack3, rdata3, fault3} !== 34'h0) begin
      $display("FAIL reset_dut3 got ack=%b rdata=%h fault=%b want 0 0 0", ack3, rdata3, fault3);
      tests_failed++;
    end
    rst = 1'b1;
  endtask

  task automatic test_wait1();
    logic [31:0] rd;
    int lat;
    xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, rd, lat);
    tests_run++;
    if (lat !== 2) begin
      $display("FAIL wait1_wr_latency got %0d want 2", lat);
      tests_failed++;
    end
    xfer(1, 1'b0, 32'h10, 32'h0, rd, lat);
    tests_run++;
    if (lat !== 2) begin
      $display("FAIL wait1_rd_latency got %0d want 2", lat);
      tests_failed++;
    end
    tests_run++;
    if (rd !== 32'hCAFE_F00D) begin
      $display("FAIL wait1_rd_data got %h want cafef00d", rd);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] exp [4];
    int lat;
    int n;
    int last;
    exp[0] = 32'h1111_0000;
    exp[1] = 32'h2222_0004;
    exp[2] = 32'h3333_0008;
    exp[3] = 32'h4444_000C;
    for (int k = 0; k < 4; k++) xfer(0, 1'b1, 32'(4 * k), exp[k], rd, lat);
    n = 0;
    last = 0;
    req = 1'b1;
    wr = 1'b0;
    addr = 32'h0;
    for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (ack0) begin
        tests_run++;
        if (rdata0 !== exp[n]) begin
          $display("FAIL b2b_data[%0d] got %h want %h", n, rdata0, exp[n]);
          tests_failed++;
        end
        tests_run++;
        if ((cyc - last) !== ((n == 0) ? 1 : 2)) begin
          $display("FAIL b2b_spacing[%0d] got %0d want %0d", n, cyc - last, (n == 0) ? 1 : 2);
          tests_failed++;
        end
        last = cyc;
        n++;
        if (n < 4) addr = 32'(4 * n);
      end else begin
        tests_run++;
        if (rdata0 !== 32'h0) begin
          $display("FAIL b2b_rdata_idle got %h want 0", rdata0);
          tests_failed++;
        end
      end
    end
    req = 1'b0;
    tests_run++;
    if (n !== 4) begin
      $display("FAIL b2b_ack_count got %0d want 4", n);
      tests_failed++;
    end
    idle(7);
  endtask

`ifdef WEAK_RAM_BOUNDS_CHECK_EN
  task automatic test_bounds();
    logic [31:0] rd;
    int lat;
    xfer(1, 1'b1, 32'h0, 32'h5555_AAAA, rd, lat);
    tests_run++;
    if (fault1 !== 1'b0) begin
      $display("FAIL bounds_fault_clean got %b want 0", fault1);
      tests_failed++;
    end
    xfer(1, 1'b0, 32'h2, 32'h0, rd, lat);
    tests_run++;
    if (lat !== 2 || rd !== 32'h0) begin
      $display("FAIL bounds_misaligned_rd got lat=%0d data=%h want lat=2 data=0", lat, rd);
      tests_failed++;
    end
    tests_run++;
    if (fault1 !== 1'b1) begin
      $display("FAIL bounds_fault_set got %b want 1", fault1);
      tests_failed++;
    end
    xfer(1, 1'b1, 32'h1000, 32'h1234_5678, rd, lat);
    tests_run++;
    if (lat !== 2) begin
      $display("FAIL bounds_oor_wr_latency got %0d want 2", lat);
      tests_failed++;
    end
    xfer(1, 1'b0, 32'h0, 32'h0, rd, lat);
    tests_run++;
    if (rd !== 32'h5555_AAAA || fault1 !== 1'b1) begin
      $display("FAIL bounds_word0_kept got data=%h fault=%b want 5555aaaa 1", rd, fault1);
      tests_failed++;
    end
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    tests_run++;
    if (fault1 !== 1'b0) begin
      $display("FAIL bounds_fault_cleared got %b want 0", fault1);
      tests_failed++;
    end
  endtask
`else
  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    xfer(1, 1'b1, 32'h1000, 32'h1234_5678, rd, lat);
    xfer(1, 1'b0, 32'h0, 32'h0, rd, lat);
    tests_run++;
    if (rd !== 32'h1234_5678) begin
      $display("FAIL wrap_data got %h want 12345678", rd);
      tests_failed++;
    end
    tests_run++;
    if (fault1 !== 1'b0) begin
      $display("FAIL wrap_fault got %b want 0", fault1);
      tests_failed++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    int acks;
    xfer(3, 1'b1, 32'h20, 32'h0, rd, lat);
    req = 1'b1;
    wr = 1'b1;
    addr = 32'h20;
    wdata = 32'hFFFF_FFFF;
    idle(1);
    req = 1'b0;
    idle(1);
    rst = 1'b0;
    #1;
    tests_run++;
    if (ack3 !== 1'b0 || rdata3 !== 32'h0) begin
      $display("FAIL rstmid_outputs got ack=%b rdata=%h want 0 0", ack3, rdata3);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack3) acks++;
    end
    tests_run++;
    if (acks !== 0) begin
      $display("FAIL rstmid_no_ack got %0d acks want 0", acks);
      tests_failed++;
    end
    xfer(3, 1'b0, 32'h20, 32'h0, rd, lat);
    tests_run++;
    if (lat !== 4 || rd !== 32'h0) begin
      $display("FAIL rstmid_readback got lat=%0d data=%h want lat=4 data=0", lat, rd);
      tests_failed++;
    end
  endtask

  task automatic test_req_drop();
    logic [31:0] rd;
    int lat;
    int acks;
    int first;
    req = 1'b1;
    wr = 1'b1;
    addr = 32'h8;
    wdata = 32'hA5A5_A5A5;
    idle(1);
    req = 1'b0;
    acks = 0;
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (ack1) begin
        acks++;
        if (first < 0) first = i;
        tests_run++;
        if (rdata1 !== 32'h0) begin
          $display("FAIL drop_wr_ack_rdata got %h want 0", rdata1);
          tests_failed++;
        end
      end
    end
    tests_run++;
    if (acks !== 1 || first !== 1) begin
      $display("FAIL drop_ack got count=%0d at=%0d want count=1 at=1", acks, first);
      tests_failed++;
    end
    idle(3);
    xfer(1, 1'b0, 32'h8, 32'h0, rd, lat);
    tests_run++;
    if (rd !== 32'hA5A5_A5A5) begin
      $display("FAIL drop_readback got %h want a5a5a5a5", rd);
      tests_failed++;
    end
  endtask

  initial begin
    req = 1'b0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    test_reset();
    test_wait1();
    test_back_to_back();
`ifdef WEAK_RAM_BOUNDS_CHECK_EN
    test_bounds();
`else
    test_wrap();
`endif
    test_reset_mid();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
